// File: rtl/cpu_ctrl_mem.sv
// Autonomous fetch-decode-execute controller for the lab CPU datapath.
// Fetches over a ready handshake and bounds every memory access with a timeout.
module cpu_ctrl_mem #(
   parameter int unsigned MAX_WAIT  = 15,
   parameter bit          FLAGS_ALL = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir,
   input  logic        mem_rdy,
   output logic [1:0]  mem_cmd,
   output logic        addr_sel,
   output logic        load_ir,
   output logic        load_pc,
   output logic        reset_pc,
   output logic        load_addr,
   output logic [2:0]  nsel,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic        loadc,
   output logic        loads,
   output logic        write,
   output logic        halted,
   output logic        err
);

   localparam int unsigned CW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   localparam logic [4:0] OP_MOVIMM = 5'b11010;
   localparam logic [4:0] OP_MOVSH  = 5'b11000;
   localparam logic [4:0] OP_MVN    = 5'b10111;
   localparam logic [4:0] OP_ADD    = 5'b10100;
   localparam logic [4:0] OP_CMP    = 5'b10101;
   localparam logic [4:0] OP_AND    = 5'b10110;
   localparam logic [4:0] OP_LDR    = 5'b01100;
   localparam logic [4:0] OP_STR    = 5'b10000;

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_UPDATEPC, S_DECODE, S_MOVIMM, S_GETA, S_GETB, S_ALU,
      S_WRITEREG, S_ADDR, S_LDADDR, S_MEMRD, S_GETD, S_SALU, S_MEMWR, S_HALT
   } state_t;

   state_t        state, next;
   logic [CW-1:0] wait_cnt;
   logic [4:0]    opc;
   logic          wait_state_c, next_wait_c, timeout_c;
   logic          unused_ir;

   assign opc       = ir[15:11];
   assign unused_ir = ^ir[10:0];

   // Wait-counter bookkeeping: states that hold a memory access open
   assign wait_state_c = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign next_wait_c  = (next == S_FETCH) || (next == S_MEMRD) || (next == S_MEMWR);
   assign timeout_c    = (MAX_WAIT != 0) && wait_state_c && !mem_rdy &&
                         (32'(wait_cnt) == MAX_WAIT - 32'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RST;
         err      <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state <= next;
         if (timeout_c)
            err <= 1'b1;
         if (next_wait_c && (next != state))
            wait_cnt <= '0;
         else if (wait_state_c && !mem_rdy && (wait_cnt != '1))
            wait_cnt <= wait_cnt + CW'(1);
      end
   end

   always_comb begin
      next      = state;
      mem_cmd   = CMD_NONE;
      addr_sel  = 1'b0;
      load_ir   = 1'b0;
      load_pc   = 1'b0;
      reset_pc  = 1'b0;
      load_addr = 1'b0;
      nsel      = 3'b000;
      vsel      = 2'b00;
      loada     = 1'b0;
      loadb     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      write     = 1'b0;
      halted    = 1'b0;

      // Reset masks whatever state is current, so no access or write leaks out
      if (reset) begin
         next     = S_RST;
         reset_pc = 1'b1;
         load_pc  = 1'b1;
      end else begin
         case (state)
            S_RST: begin
               reset_pc = 1'b1;
               load_pc  = 1'b1;
               next     = S_FETCH;
            end
            S_FETCH: begin
               mem_cmd = CMD_READ;
               load_ir = mem_rdy;
               if (mem_rdy)        next = S_UPDATEPC;
               else if (timeout_c) next = S_HALT;
            end
            S_UPDATEPC: begin
               load_pc = 1'b1;
               next    = S_DECODE;
            end
            S_DECODE: begin
               case (opc)
                  OP_MOVIMM:                               next = S_MOVIMM;
                  OP_MOVSH, OP_MVN:                        next = S_GETB;
                  OP_ADD, OP_CMP, OP_AND, OP_LDR, OP_STR:  next = S_GETA;
                  default: next = (ir[15:13] == 3'b111) ? S_HALT : S_FETCH;
               endcase
            end
            S_MOVIMM: begin
               nsel  = 3'b100;
               vsel  = 2'b10;
               write = 1'b1;
               next  = S_FETCH;
            end
            S_GETA: begin
               nsel  = 3'b100;
               loada = 1'b1;
               next  = ((opc == OP_LDR) || (opc == OP_STR)) ? S_ADDR : S_GETB;
            end
            S_GETB: begin
               nsel  = 3'b001;
               loadb = 1'b1;
               next  = S_ALU;
            end
            S_ALU: begin
               loadc = 1'b1;
               asel  = (opc == OP_MOVSH) || (opc == OP_MVN);
               loads = (opc == OP_CMP) || FLAGS_ALL;
               next  = (opc == OP_CMP) ? S_FETCH : S_WRITEREG;
            end
            S_WRITEREG: begin
               nsel  = 3'b010;
               write = 1'b1;
               next  = S_FETCH;
            end
            S_ADDR: begin
               bsel  = 1'b1;
               loadc = 1'b1;
               next  = S_LDADDR;
            end
            S_LDADDR: begin
               load_addr = 1'b1;
               next      = (ir[15:13] == 3'b011) ? S_MEMRD : S_GETD;
            end
            S_MEMRD: begin
               mem_cmd  = CMD_READ;
               addr_sel = 1'b1;
               if (mem_rdy) begin
                  nsel  = 3'b010;
                  vsel  = 2'b01;
                  write = 1'b1;
                  next  = S_FETCH;
               end else if (timeout_c) begin
                  next = S_HALT;
               end
            end
            S_GETD: begin
               nsel  = 3'b010;
               loadb = 1'b1;
               next  = S_SALU;
            end
            S_SALU: begin
               asel  = 1'b1;
               loadc = 1'b1;
               next  = S_MEMWR;
            end
            S_MEMWR: begin
               mem_cmd  = CMD_WRITE;
               addr_sel = 1'b1;
               if (mem_rdy)        next = S_FETCH;
               else if (timeout_c) next = S_HALT;
            end
            S_HALT: begin
               halted = 1'b1;
            end
            default: next = S_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ctrl_mem.sv
// Directed cycle-by-cycle bench for cpu_ctrl_mem; expected output vectors
// are queued per step and checked at the falling edge.
module tb_cpu_ctrl_mem;

   typedef struct packed {
      logic [1:0] cmd;
      logic       asl, lir, lpc, rpc, lad;
      logic [2:0] ns;
      logic [1:0] vs;
      logic       la, lb, as, bs, lc, ls, wr, hl, er;
   } ov_t;

   typedef struct {
      string tag;
      ov_t   exp;
      ov_t   mask;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ir;
   logic        mem_rdy;
   logic [1:0]  mem_cmd;
   logic        addr_sel, load_ir, load_pc, reset_pc, load_addr;
   logic [2:0]  nsel;
   logic [1:0]  vsel;
   logic        loada, loadb, asel, bsel, loadc, loads, write, halted, err;

   ov_t obs;
   sb_t sb_q[$];
   int  tests = 0;
   int  fails = 0;

   ov_t full, rmask;
   ov_t e_rst, e_fetch, e_fetch_w, e_upd, e_dec, e_movimm, e_geta, e_getb;
   ov_t e_alu, e_alu_cmp, e_alu_sh, e_wr, e_addr, e_ldaddr, e_memrd_w, e_memrd;
   ov_t e_getd, e_salu, e_memwr, e_halt, e_halt_err;

   cpu_ctrl_mem #(.MAX_WAIT(15), .FLAGS_ALL(1'b0)) dut (
      .clk(clk), .reset(reset), .ir(ir), .mem_rdy(mem_rdy),
      .mem_cmd(mem_cmd), .addr_sel(addr_sel), .load_ir(load_ir),
      .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
      .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
      .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
      .write(write), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   assign obs = {mem_cmd, addr_sel, load_ir, load_pc, reset_pc, load_addr,
                 nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write,
                 halted, err};

   task automatic step(input string tag, input ov_t exp, input logic rdy, input ov_t mask);
      sb_t e;
      logic [20:0] got, want;
      mem_rdy = rdy;
      sb_q.push_back('{tag, exp, mask});
      @(negedge clk);
      e    = sb_q.pop_front();
      got  = obs & e.mask;
      want = e.exp & e.mask;
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", e.tag, got, want);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input ov_t exp, input logic rdy);
      step(tag, exp, rdy, full);
   endtask

   initial begin
      full  = '1;
      rmask = '0; rmask.cmd = 2'b11; rmask.lir = 1'b1; rmask.wr = 1'b1;
      e_rst      = '0; e_rst.lpc = 1'b1; e_rst.rpc = 1'b1;
      e_fetch    = '0; e_fetch.cmd = 2'b01; e_fetch.lir = 1'b1;
      e_fetch_w  = '0; e_fetch_w.cmd = 2'b01;
      e_upd      = '0; e_upd.lpc = 1'b1;
      e_dec      = '0;
      e_movimm   = '0; e_movimm.ns = 3'b100; e_movimm.vs = 2'b10; e_movimm.wr = 1'b1;
      e_geta     = '0; e_geta.ns = 3'b100; e_geta.la = 1'b1;
      e_getb     = '0; e_getb.ns = 3'b001; e_getb.lb = 1'b1;
      e_alu      = '0; e_alu.lc = 1'b1;
      e_alu_cmp  = '0; e_alu_cmp.lc = 1'b1; e_alu_cmp.ls = 1'b1;
      e_alu_sh   = '0; e_alu_sh.lc = 1'b1; e_alu_sh.as = 1'b1;
      e_wr       = '0; e_wr.ns = 3'b010; e_wr.wr = 1'b1;
      e_addr     = '0; e_addr.bs = 1'b1; e_addr.lc = 1'b1;
      e_ldaddr   = '0; e_ldaddr.lad = 1'b1;
      e_memrd_w  = '0; e_memrd_w.cmd = 2'b01; e_memrd_w.asl = 1'b1;
      e_memrd    = e_memrd_w; e_memrd.ns = 3'b010; e_memrd.vs = 2'b01; e_memrd.wr = 1'b1;
      e_getd     = '0; e_getd.ns = 3'b010; e_getd.lb = 1'b1;
      e_salu     = '0; e_salu.as = 1'b1; e_salu.lc = 1'b1;
      e_memwr    = '0; e_memwr.cmd = 2'b10; e_memwr.asl = 1'b1;
      e_halt     = '0; e_halt.hl = 1'b1;
      e_halt_err = e_halt; e_halt_err.er = 1'b1;

      reset = 1'b1; ir = 16'h0000; mem_rdy = 1'b0;
      @(posedge clk); #1;

      // Reset held two cycles: no access, load_ir or write may escape
      step("reset_hold0", e_rst, 1'b1, rmask);
      step("reset_hold1", e_rst, 1'b1, rmask);
      reset = 1'b0;
      chk("rst", e_rst, 1'b1);

      // MOV R1,#7
      ir = 16'hD107;
      chk("mov_fetch", e_fetch, 1'b1);
      chk("mov_upd", e_upd, 1'b1);
      chk("mov_dec", e_dec, 1'b1);
      chk("mov_imm", e_movimm, 1'b1);

      // ADD R5,R0,R2
      ir = 16'hA0A2;
      chk("add_fetch", e_fetch, 1'b1);
      chk("add_upd", e_upd, 1'b1);
      chk("add_dec", e_dec, 1'b1);
      chk("add_geta", e_geta, 1'b1);
      chk("add_getb", e_getb, 1'b1);
      chk("add_alu", e_alu, 1'b1);
      chk("add_wr", e_wr, 1'b1);

      // CMP R0,R2: six cycles, flags only, no writeback
      ir = 16'hA802;
      chk("cmp_fetch", e_fetch, 1'b1);
      chk("cmp_upd", e_upd, 1'b1);
      chk("cmp_dec", e_dec, 1'b1);
      chk("cmp_geta", e_geta, 1'b1);
      chk("cmp_getb", e_getb, 1'b1);
      chk("cmp_alu", e_alu_cmp, 1'b1);

      // MVN skips GETA and uses asel
      ir = 16'hB800;
      chk("mvn_fetch", e_fetch, 1'b1);
      chk("mvn_upd", e_upd, 1'b1);
      chk("mvn_dec", e_dec, 1'b1);
      chk("mvn_getb", e_getb, 1'b1);
      chk("mvn_alu", e_alu_sh, 1'b1);
      chk("mvn_wr", e_wr, 1'b1);

      // Unknown opcode behaves as a 3-cycle NOP
      ir = 16'h0000;
      chk("nop_fetch", e_fetch, 1'b1);
      chk("nop_upd", e_upd, 1'b1);
      chk("nop_dec", e_dec, 1'b1);

      // LDR R1,[R0,#1] with three memory wait cycles
      ir = 16'h6021;
      chk("ldr_fetch", e_fetch, 1'b1);
      chk("ldr_upd", e_upd, 1'b1);
      chk("ldr_dec", e_dec, 1'b1);
      chk("ldr_geta", e_geta, 1'b1);
      chk("ldr_addr", e_addr, 1'b1);
      chk("ldr_ldaddr", e_ldaddr, 1'b1);
      for (int i = 0; i < 3; i++) chk("ldr_memrd_wait", e_memrd_w, 1'b0);
      chk("ldr_memrd", e_memrd, 1'b1);

      // STR R2,[R0,#3]
      ir = 16'h8043;
      chk("str_fetch", e_fetch, 1'b1);
      chk("str_upd", e_upd, 1'b1);
      chk("str_dec", e_dec, 1'b1);
      chk("str_geta", e_geta, 1'b1);
      chk("str_addr", e_addr, 1'b1);
      chk("str_ldaddr", e_ldaddr, 1'b1);
      chk("str_getd", e_getd, 1'b1);
      chk("str_salu", e_salu, 1'b1);
      chk("str_memwr", e_memwr, 1'b1);

      // HALT holds regardless of mem_rdy until reset
      ir = 16'hE000;
      chk("halt_fetch", e_fetch, 1'b1);
      chk("halt_upd", e_upd, 1'b1);
      chk("halt_dec", e_dec, 1'b1);
      for (int i = 0; i < 20; i++) chk("halt_hold", e_halt, 1'($urandom_range(0, 1)));
      reset = 1'b1;
      step("halt_reset", e_rst, 1'b1, rmask);
      reset = 1'b0;
      chk("halt_rst", e_rst, 1'b1);

      // Fetch timeout: 15 wait cycles then HALT with err
      ir = 16'h0000;
      for (int i = 0; i < 15; i++) chk("to_fetch_wait", e_fetch_w, 1'b0);
      for (int i = 0; i < 3; i++) chk("to_halt_err", e_halt_err, 1'b0);
      reset = 1'b1;
      step("to_reset", e_rst, 1'b0, rmask);
      reset = 1'b0;
      chk("to_rst_err_clear", e_rst, 1'b0);

      // Ready on wait cycle 15 completes normally
      for (int i = 0; i < 14; i++) chk("edge_fetch_wait", e_fetch_w, 1'b0);
      chk("edge_fetch_rdy", e_fetch, 1'b1);
      chk("edge_upd", e_upd, 1'b1);
      chk("edge_dec", e_dec, 1'b1);
      chk("edge_refetch", e_fetch, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_mem.md
# cpu_ctrl_mem

Parametrised successor to the lab CPU control unit. It replaces the externally loaded instruction and the `s`/`w` start handshake with an autonomous fetch–decode–execute controller. The controller fetches from memory over a ready handshake, advances the PC, and executes MOV, ALU, CMP, LDR, STR and HALT instructions. It drives the existing datapath and the new memory/PC/address registers, and it guards every memory access with a configurable timeout.

## Interface
- `MAX_WAIT`, 15: maximum cycles spent waiting for `mem_rdy` in one access. 0 disables the timeout.
- `FLAGS_ALL`, 0: 0 means only CMP asserts `loads`. 1 means ADD, AND, MVN and MOV-shifted also assert `loads` in their ALU cycle.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ir` in 16: instruction register contents. `ir[15:13]` is the opcode and `ir[12:11]` is op.
- `mem_rdy` in 1: memory completes the current access this cycle.
- `mem_cmd` out 2: memory command. 00 none, 01 read, 10 write.
- `addr_sel` out 1: memory address source. 0 is PC, 1 is the data address register.
- `load_ir`, `load_pc`, `reset_pc`, `load_addr` out 1 each: register enables.
- `nsel` out 3: one-hot register select. 100 = Rn, 010 = Rd, 001 = Rm.
- `vsel` out 2: writeback source. 00 C, 01 mdata, 10 sximm8, 11 PC.
- `loada`, `loadb`, `asel`, `bsel`, `loadc`, `loads`, `write` out 1 each: datapath controls, same meaning as in the current datapath.
- `halted` out 1: controller is in HALT.
- `err` out 1: HALT was entered through a memory timeout.

## Operation
- Outputs are Moore, decoded from state. Exceptions are `load_ir` and the LDR writeback signals, which are additionally gated by `mem_rdy`.
- Any signal not listed for a state is 0. `nsel` defaults to 000 and `vsel` to 00.
- Reset: state goes to RST. All outputs are 0 except in RST, where `reset_pc = load_pc = 1`. `err` is cleared.

States, their outputs and next state:
- RST: `reset_pc`, `load_pc`. Next: FETCH.
- FETCH: `mem_cmd = 01`, `addr_sel = 0`, `load_ir = mem_rdy`. Stays in FETCH until `mem_rdy`, then UPDATEPC.
- UPDATEPC: `load_pc` (PC+1). Next: DECODE.
- DECODE: no outputs. Next state by `{opcode, op}`:
  - 11010 → MOVIMM.
  - 11000 or 10111 → GETB.
  - 10100, 10101 or 10110 → GETA.
  - 01100 or 10000 → GETA.
  - opcode 111 → HALT.
  - anything else → FETCH (treated as a NOP).
- MOVIMM: `nsel = 100`, `vsel = 10`, `write`. Next: FETCH.
- GETA: `nsel = 100`, `loada`. Next: ADDR for LDR/STR, otherwise GETB.
- GETB: `nsel = 001`, `loadb`. Next: ALU.
- ALU: `loadc`.
  - `asel = 1` for MOV-shifted and MVN, otherwise 0. `bsel = 0`.
  - `loads = 1` for CMP, or for any ALU op when `FLAGS_ALL = 1`.
  - Next: FETCH for CMP (no writeback), otherwise WRITEREG.
- WRITEREG: `nsel = 010`, `vsel = 00`, `write`. Next: FETCH.
- ADDR: `asel = 0`, `bsel = 1` (sximm5), `loadc`. Next: LDADDR.
- LDADDR: `load_addr`. Next: MEMRD for LDR, GETD for STR.
- MEMRD: `mem_cmd = 01`, `addr_sel = 1`. When `mem_rdy` is high, `nsel = 010`, `vsel = 01` and `write` are also asserted. Stays until `mem_rdy`, then FETCH.
- GETD: `nsel = 010`, `loadb`. Next: SALU.
- SALU: `asel = 1`, `bsel = 0`, `loadc`. Next: MEMWR.
- MEMWR: `mem_cmd = 10`, `addr_sel = 1`. Stays until `mem_rdy`, then FETCH.
- HALT: `halted = 1`. Stays in HALT until `reset`.

Wait counter:
- The counter clears on entry to FETCH, MEMRD and MEMWR.
- In those states it increments each cycle that `mem_rdy = 0`.
- If `MAX_WAIT ≠ 0` and the wait reaches cycle `MAX_WAIT` (counting the first cycle in the state as 1) with `mem_rdy` still 0, the next state is HALT and `err` is set.
- `mem_rdy = 1` on cycle `MAX_WAIT` completes the access normally.
- Counter width is `$clog2(MAX_WAIT+1)`, minimum 1, and it saturates.

## Timing
Cycle counts with `mem_rdy` tied high, counted from entry into FETCH to re-entry into FETCH:

| Instruction | Cycles |
|---|---|
| MOV imm | 4 |
| CMP | 6 |
| ADD / AND / MVN / MOV-shifted (MOV-sh and MVN skip GETA) | 7 / 7 / 6 / 6 |
| LDR | 7 |
| STR | 9 |
| Unknown opcode | 3 |
| HALT | 3 cycles to reach HALT |

- Each memory wait cycle adds exactly 1 cycle.
- `reset` overrides every state, including HALT and mid-access states. In the reset cycle no `write`, `mem_cmd` or `load_ir` may be asserted.
- `ir` is sampled only in DECODE and later states; `ir` must be stable from UPDATEPC through the end of the instruction.
- `err` and `halted` stay asserted until reset.

## Test plan
1. **Reset.** Hold `reset` for 2 cycles, then release. Expect the RST cycle with `reset_pc = load_pc = 1`, then FETCH with `mem_cmd = 01`, `addr_sel = 0`, and all other outputs 0.
2. **MOV immediate.** Drive `ir = 16'hD107` (MOV R1,#7) with `mem_rdy` high. Expect MOVIMM 3 cycles after FETCH with `nsel = 100`, `vsel = 10`, `write = 1`, then FETCH on the next cycle.
3. **ADD vs CMP.** Run `ir = 16'hA0A2` (ADD R5,R0,R2), then `16'hA802` (CMP R0,R2), with `FLAGS_ALL = 0`.
   - ADD: expect the GETA/GETB/ALU/WRITEREG sequence with `loads = 0`.
   - CMP: expect `loads = 1` in ALU, no `write`, and a 6-cycle instruction.
4. **LDR with slow memory.** Run `ir = 16'h6021` (LDR R1,[R0,#1]) with `mem_rdy` low for 3 cycles in MEMRD. Expect `mem_cmd = 01`, `addr_sel = 1` for 4 cycles, with `write`, `vsel = 01`, `nsel = 010` only in the 4th cycle.
5. **STR and HALT.** Run `ir = 16'h8043` (STR R2,[R0,#3]). Expect the 9-cycle sequence with `mem_cmd = 10` in the last cycle. Then run `ir = 16'hE000`. Expect `halted = 1` and the state held for 20 cycles until `reset`.
6. **Timeout.** Keep `mem_rdy = 0` in FETCH with `MAX_WAIT = 15`. Expect HALT with `err = 1` in the cycle after the 15th wait cycle. Repeat with `mem_rdy = 1` on wait cycle 15. Expect a normal UPDATEPC and `err = 0`.
